// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default counter sizing.
// Also used by the generator side.
package pwm_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        LOW       = 2'd3
    } pwm_state_t;

    localparam int unsigned PWM_WIDTH_DEF   = 28;
    localparam int unsigned PWM_TIMEOUT_DEF = 50_000_000;

    // Edges needed after reset before the synchronised level reflects the pin
    localparam logic [1:0] SETTLE_CYCLES = 2'd3;

endpackage

// File: rtl/pwm_capture_if.sv
// Result/handshake bundle between the PWM capture block and the Nios PIO.
// The capture side is the slave; the Nios side is the master.
interface pwm_capture_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH_DEF
);
    logic             ACK;
    logic [WIDTH-1:0] PERIOD;
    logic [WIDTH-1:0] HIGH_TIME;
    logic             NEW;
    logic             OVERRUN;
    logic             STUCK;
    logic             LEVEL;

    modport master (
        output ACK,
        input  PERIOD, HIGH_TIME, NEW, OVERRUN, STUCK, LEVEL
    );

    modport slave (
        input  ACK,
        output PERIOD, HIGH_TIME, NEW, OVERRUN, STUCK, LEVEL
    );

endinterface

// File: rtl/pwm_capture_sync_edge_det.sv
// Two-flop synchroniser plus registered edge detector for an asynchronous pin.
// level is aligned with rise/fall: it is 1 in the cycle a rise pulse is seen.
module sync_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Synchroniser, previous-level register and one-cycle edge pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    assign level = prev_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time measurement with stuck-line timeout.
// Results are published to a Nios PIO and handshaken with ACK.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH   = PWM_WIDTH_DEF,
    parameter int unsigned TIMEOUT = PWM_TIMEOUT_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PWM_IN,
    pwm_capture_if.slave  bus
);

    localparam logic [WIDTH-1:0] CNT_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

    logic             level_s;
    logic             rise_s;
    logic             fall_s;
    logic             settled_s;
    logic             timeout_s;
    logic             meas_done_s;
    logic             publish_s;

    pwm_state_t       state_r;
    logic [1:0]       settle_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] hi_lat_r;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] high_time_r;
    logic             new_r;
    logic             overrun_r;
    logic             stuck_r;
    logic             level_r;

    sync_edge_det u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .d     (PWM_IN),
        .level (level_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // An edge in the same cycle as cnt==TIMEOUT suppresses the timeout
    assign settled_s   = (settle_r == SETTLE_CYCLES);
    assign timeout_s   = (cnt_r == TIMEOUT_CNT) && !rise_s && !fall_s;
    assign meas_done_s = (state_r == LOW) && rise_s;
    assign publish_s   = meas_done_s || timeout_s;

    // Hold off WAIT_LOW until the sync pipeline has seen the pin after reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_r <= 2'd0;
        end else if (!settled_s) begin
            settle_r <= settle_r + 2'd1;
        end else begin
            settle_r <= settle_r;
        end
    end

    // Cycle counter: restarts on every rise and on timeout, saturates at all-ones
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= CNT_ONE;
        end else if (rise_s || timeout_s) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Measurement FSM, high-time latch and published result/flag registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= WAIT_LOW;
            hi_lat_r    <= {WIDTH{1'b0}};
            period_r    <= {WIDTH{1'b0}};
            high_time_r <= {WIDTH{1'b0}};
            new_r       <= 1'b0;
            overrun_r   <= 1'b0;
            stuck_r     <= 1'b0;
            level_r     <= 1'b0;
        end else begin
            if (timeout_s) begin
                state_r <= level_s ? WAIT_LOW : WAIT_RISE;
            end else begin
                case (state_r)
                    WAIT_LOW: begin
                        if (settled_s && !level_s) begin
                            state_r <= WAIT_RISE;
                        end else begin
                            state_r <= WAIT_LOW;
                        end
                    end
                    WAIT_RISE: begin
                        if (rise_s) begin
                            state_r <= HIGH;
                        end else begin
                            state_r <= WAIT_RISE;
                        end
                    end
                    HIGH: begin
                        if (fall_s) begin
                            state_r  <= LOW;
                            hi_lat_r <= cnt_r;
                        end else begin
                            state_r <= HIGH;
                        end
                    end
                    LOW: begin
                        if (rise_s) begin
                            state_r <= HIGH;
                        end else begin
                            state_r <= LOW;
                        end
                    end
                    default: begin
                        state_r <= WAIT_LOW;
                    end
                endcase
            end

            // A publish outranks a coincident ACK so no result is silently lost
            if (publish_s) begin
                period_r    <= timeout_s ? {WIDTH{1'b0}} : cnt_r;
                high_time_r <= timeout_s ? {WIDTH{1'b0}} : hi_lat_r;
                stuck_r     <= timeout_s;
                level_r     <= timeout_s ? level_s : level_r;
                new_r       <= 1'b1;
                overrun_r   <= overrun_r | (new_r & ~bus.ACK);
            end else if (bus.ACK && new_r) begin
                new_r     <= 1'b0;
                overrun_r <= 1'b0;
            end else begin
                new_r     <= new_r;
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.PERIOD    = period_r;
    assign bus.HIGH_TIME = high_time_r;
    assign bus.NEW       = new_r;
    assign bus.OVERRUN   = overrun_r;
    assign bus.STUCK     = stuck_r;
    assign bus.LEVEL     = level_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a long-timeout instance for measurement,
// handshake and reset behaviour, and a short-timeout instance for stuck detection.
module tb_pwm_capture;

    localparam int W = 16;

    typedef struct {
        int due;
        bit sel;
        bit full;
        int per;
        int hi;
        bit stuck;
        bit lvl;
        bit nw;
        bit ovr;
    } exp_t;

    logic clk;
    logic rst;
    logic pin_l;
    logic pin_s;

    int   checks;
    int   errors;
    int   cyc;
    exp_t sb[$];

    pwm_capture_if #(.WIDTH(W)) bus_l ();
    pwm_capture_if #(.WIDTH(W)) bus_s ();

    pwm_capture #(.WIDTH(W), .TIMEOUT(2000)) dut_l (
        .CLK    (clk),
        .RST    (rst),
        .PWM_IN (pin_l),
        .bus    (bus_l.slave)
    );

    pwm_capture #(.WIDTH(W), .TIMEOUT(100)) dut_s (
        .CLK    (clk),
        .RST    (rst),
        .PWM_IN (pin_s),
        .bus    (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int due, input bit sel, input bit full, input int per, input int hi,
                        input bit st, input bit lv, input bit nw, input bit ov);
        exp_t e;
        e.due = due; e.sel = sel; e.full = full; e.per = per; e.hi = hi;
        e.stuck = st; e.lvl = lv; e.nw = nw; e.ovr = ov;
        sb.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        logic [W-1:0] per;
        logic [W-1:0] hi;
        logic         st;
        logic         lv;
        logic         nw;
        logic         ov;
        if (e.sel) begin
            per = bus_s.PERIOD; hi = bus_s.HIGH_TIME; st = bus_s.STUCK;
            lv = bus_s.LEVEL; nw = bus_s.NEW; ov = bus_s.OVERRUN;
        end else begin
            per = bus_l.PERIOD; hi = bus_l.HIGH_TIME; st = bus_l.STUCK;
            lv = bus_l.LEVEL; nw = bus_l.NEW; ov = bus_l.OVERRUN;
        end
        if (e.full) begin
            chk(e.sel ? "s_period" : "l_period", 32'(per), e.per);
            chk(e.sel ? "s_high_time" : "l_high_time", 32'(hi), e.hi);
            chk(e.sel ? "s_stuck" : "l_stuck", 32'(st), 32'(e.stuck));
            chk(e.sel ? "s_level" : "l_level", 32'(lv), 32'(e.lvl));
        end
        chk(e.sel ? "s_new" : "l_new", 32'(nw), 32'(e.nw));
        chk(e.sel ? "s_overrun" : "l_overrun", 32'(ov), 32'(e.ovr));
    endtask

    // One clock: advance to the falling edge, then retire every due expectation
    task automatic tick();
        int i;
        exp_t e;
        @(negedge clk);
        cyc++;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                e = sb[i];
                sb.delete(i);
                compare(e);
            end else begin
                i++;
            end
        end
    endtask

    task automatic chk_zero(input bit sel);
        if (sel) begin
            chk("rst_s_period", 32'(bus_s.PERIOD), 32'd0);
            chk("rst_s_high", 32'(bus_s.HIGH_TIME), 32'd0);
            chk("rst_s_flags", 32'({bus_s.NEW, bus_s.OVERRUN, bus_s.STUCK, bus_s.LEVEL}), 32'd0);
        end else begin
            chk("rst_l_period", 32'(bus_l.PERIOD), 32'd0);
            chk("rst_l_high", 32'(bus_l.HIGH_TIME), 32'd0);
            chk("rst_l_flags", 32'({bus_l.NEW, bus_l.OVERRUN, bus_l.STUCK, bus_l.LEVEL}), 32'd0);
        end
    endtask

    // One PWM period on the long instance; the rise closes the previous period
    // (expected ep/eh), ACK is pulsed at tick index ack_at (-1 for none).
    task automatic wave(input int hi, input int lo, input bit do_push, input int ep, input int eh,
                        input bit eovr, input int ack_at);
        pin_l = 1'b1;
        if (do_push) begin
            push(cyc + 4, 1'b0, 1'b1, ep, eh, 1'b0, 1'b0, 1'b1, eovr);
            if (ack_at > 3) begin
                push(cyc + ack_at + 1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) pin_l = 1'b0;
            bus_l.ACK = (i == ack_at);
            tick();
        end
        bus_l.ACK = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        pin_l  = 1'b0;
        pin_s  = 1'b0;
        bus_l.ACK = 1'b0;
        bus_s.ACK = 1'b0;
        repeat (3) tick();
        chk_zero(1'b0);
        chk_zero(1'b1);
        rst = 1'b0;
        repeat (6) tick();

        // Stuck high on the short-timeout instance: timeout 100 cycles after the rise pulse, then every 100
        pin_s = 1'b1;
        push(cyc + 104, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        push(cyc + 204, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (210) tick();

        // 3 high / 7 low: first rise arms, second publishes 10/3; ACK clears NEW
        wave(3, 7, 1'b0, 0, 0, 1'b0, -1);
        wave(3, 7, 1'b1, 10, 3, 1'b0, 4);

        // Switch to 1000 high / 250 low in the middle of a period
        wave(3, 250, 1'b1, 10, 3, 1'b0, 4);
        wave(1000, 250, 1'b1, 253, 3, 1'b0, 4);
        wave(1000, 250, 1'b1, 1250, 1000, 1'b0, 4);
        wave(1000, 250, 1'b1, 1250, 1000, 1'b0, 4);

        // Overrun without ACK, then ACK coincident with publish
        wave(1000, 250, 1'b1, 1250, 1000, 1'b0, -1);
        wave(3, 7, 1'b1, 1250, 1000, 1'b1, -1);
        wave(3, 7, 1'b1, 10, 3, 1'b1, 3);
        wave(3, 7, 1'b1, 10, 3, 1'b1, 4);
        wave(3, 7, 1'b1, 10, 3, 1'b0, 3);

        // Minimum waveform 1 high / 1 low, acknowledged between publishes
        wave(1, 1, 1'b1, 10, 3, 1'b0, 0);
        for (int k = 0; k < 19; k++) begin
            wave(1, 1, 1'b1, 2, 1, 1'b0, 0);
        end
        bus_l.ACK = 1'b1;
        tick();
        bus_l.ACK = 1'b0;
        repeat (10) tick();

        // Reset while HIGH with the pin held high; no publish until a full low/rise/fall/rise
        pin_l = 1'b1;
        push(cyc + 4, 1'b0, 1'b1, 13, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk_zero(1'b0);
        rst = 1'b0;
        repeat (20) tick();
        chk("post_rst_new_high", 32'(bus_l.NEW), 32'd0);
        pin_l = 1'b0;
        repeat (10) tick();
        wave(5, 5, 1'b0, 0, 0, 1'b0, -1);
        chk("post_rst_new_armed", 32'(bus_l.NEW), 32'd0);
        wave(5, 5, 1'b1, 10, 5, 1'b0, 4);
        repeat (10) tick();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
